// File: rtl/vend_pkg.sv
// Shared definitions for the vending change dispenser: FSM states, coin
// identities and values, and coin-tube geometry.
package vend_pkg;

    localparam int TUBE_W = 4;
    localparam logic [TUBE_W-1:0] TUBE_MAX = 4'd15;

    // Coin values expressed in nickel units
    localparam logic [4:0] Q_VAL = 5'd5;
    localparam logic [4:0] D_VAL = 5'd2;
    localparam logic [4:0] N_VAL = 5'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_SHORT = 3'd5
    } vend_state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_N    = 2'd1,
        COIN_D    = 2'd2,
        COIN_Q    = 2'd3
    } coin_t;

    function automatic logic [4:0] coin_value(input coin_t c);
        logic [4:0] v;
        case (c)
            COIN_Q:  v = Q_VAL;
            COIN_D:  v = D_VAL;
            COIN_N:  v = N_VAL;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_coin_tube.sv
// One coin tube: saturating up/down count of coins held, with a fill-to-max.
module vend_coin_tube
    import vend_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              fill,
    output logic [TUBE_W-1:0] count
);

    // Simultaneous deposit and eject cancel; fill takes precedence over both.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (fill) begin
            count <= TUBE_MAX;
        end else if (inc && !dec) begin
            if (count != TUBE_MAX) begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Greedy change dispenser: pays rem_nk in Q/D/N coins from three tubes,
// one coin every three cycles, ending with a done or short strobe.
module vend_change_dispenser
    import vend_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        change_nk,
    input  logic              N_in,
    input  logic              D_in,
    input  logic              Q_in,
    input  logic              refill,
    output logic              N_out,
    output logic              D_out,
    output logic              Q_out,
    output logic              busy,
    output logic              done,
    output logic              short,
    output logic [4:0]        rem_nk,
    output logic [TUBE_W-1:0] N_cnt,
    output logic [TUBE_W-1:0] D_cnt,
    output logic [TUBE_W-1:0] Q_cnt,
    output vend_state_t       state_dbg
);

    // Handshake: start is a one-cycle strobe accepted only while busy is low;
    // there is no back-pressure, so a start seen while busy is dropped.

    vend_state_t state, state_next;
    coin_t       coin_sel, coin_next;
    logic        tube_fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            coin_sel <= COIN_NONE;
        end else begin
            state    <= state_next;
            coin_sel <= coin_next;
        end
    end

    always_comb begin
        state_next = state;
        coin_next  = coin_sel;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_PICK;
                end
            end
            S_PICK: begin
                coin_next = COIN_NONE;
                if (rem_nk == 5'd0) begin
                    state_next = S_DONE;
                end else if (rem_nk >= Q_VAL && Q_cnt != '0) begin
                    coin_next  = COIN_Q;
                    state_next = S_PULSE;
                end else if (rem_nk >= D_VAL && D_cnt != '0) begin
                    coin_next  = COIN_D;
                    state_next = S_PULSE;
                end else if (rem_nk >= N_VAL && N_cnt != '0) begin
                    coin_next  = COIN_N;
                    state_next = S_PULSE;
                end else begin
                    state_next = S_SHORT;
                end
            end
            S_PULSE: state_next = S_GAP;
            S_GAP:   state_next = S_PICK;
            S_DONE:  state_next = S_IDLE;
            S_SHORT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // rem_nk is left untouched on SHORT so the unpaid amount stays visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_nk <= 5'd0;
        end else if (state == S_IDLE && start) begin
            rem_nk <= change_nk;
        end else if (state == S_PULSE) begin
            rem_nk <= rem_nk - coin_value(coin_sel);
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        short     = (state == S_SHORT);
        Q_out     = (state == S_PULSE) && (coin_sel == COIN_Q);
        D_out     = (state == S_PULSE) && (coin_sel == COIN_D);
        N_out     = (state == S_PULSE) && (coin_sel == COIN_N);
        tube_fill = refill && (state == S_IDLE);
        state_dbg = state;
    end

    vend_coin_tube u_tube_n (
        .clk   (clk),
        .reset (reset),
        .inc   (N_in),
        .dec   (N_out),
        .fill  (tube_fill),
        .count (N_cnt)
    );

    vend_coin_tube u_tube_d (
        .clk   (clk),
        .reset (reset),
        .inc   (D_in),
        .dec   (D_out),
        .fill  (tube_fill),
        .count (D_cnt)
    );

    vend_coin_tube u_tube_q (
        .clk   (clk),
        .reset (reset),
        .inc   (Q_in),
        .dec   (Q_out),
        .fill  (tube_fill),
        .count (Q_cnt)
    );

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: cycle-scheduled behavioural model,
// directed scenarios with literal event timing, then random traffic.
module tb_vend_change_dispenser;
    import vend_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  change_nk = 5'd0;
    logic        N_in = 1'b0, D_in = 1'b0, Q_in = 1'b0, refill = 1'b0;
    logic        N_out, D_out, Q_out, busy, done, short;
    logic [4:0]  rem_nk;
    logic [3:0]  N_cnt, D_cnt, Q_cnt;
    vend_state_t state_dbg;

    vend_change_dispenser dut (
        .clk(clk), .reset(reset), .start(start), .change_nk(change_nk),
        .N_in(N_in), .D_in(D_in), .Q_in(Q_in), .refill(refill),
        .N_out(N_out), .D_out(D_out), .Q_out(Q_out),
        .busy(busy), .done(done), .short(short), .rem_nk(rem_nk),
        .N_cnt(N_cnt), .D_cnt(D_cnt), .Q_cnt(Q_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: money owed, coins per tube (0=N,1=D,2=Q), and the absolute
    // cycle numbers of the next greedy decision and the next visible event.
    localparam int VAL [3] = '{1, 2, 5};
    bit m_active = 0;
    int m_rem = 0;
    int m_cnt [3] = '{0, 0, 0};
    int pick_cyc = -1;
    int ev_cyc = -1;
    int ev_kind = -1;        // 0..2 coin, 3 done, 4 short
    bit e_out [3] = '{0, 0, 0};
    bit e_done = 0, e_short = 0;

    // Observed events for directed literal checks
    int obs_kind [$];
    int obs_cyc [$];
    int busy_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit inc [3];
        inc = '{N_in, D_in, Q_in};
        if (reset) begin
            m_active = 0; m_rem = 0; m_cnt = '{0, 0, 0};
            pick_cyc = -1; ev_cyc = -1; ev_kind = -1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (refill && !m_active) m_cnt[i] = 15;
                else if (inc[i] && !e_out[i]) m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
                else if (!inc[i] && e_out[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                if (e_out[i]) m_rem = m_rem - VAL[i];
            end
            if (e_done || e_short) begin
                m_active = 0;
            end else if (!m_active && start) begin
                m_active = 1;
                m_rem = int'(change_nk);
                pick_cyc = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic model_cycle();
        e_out = '{0, 0, 0};
        e_done = 0;
        e_short = 0;
        if (m_active && cyc == pick_cyc) begin
            if (m_rem == 0) ev_kind = 3;
            else if (m_rem >= 5 && m_cnt[2] > 0) ev_kind = 2;
            else if (m_rem >= 2 && m_cnt[1] > 0) ev_kind = 1;
            else if (m_rem >= 1 && m_cnt[0] > 0) ev_kind = 0;
            else ev_kind = 4;
            ev_cyc = cyc + 1;
            if (ev_kind < 3) pick_cyc = cyc + 3;
        end
        if (m_active && cyc == ev_cyc) begin
            if (ev_kind < 3) e_out[ev_kind] = 1;
            else if (ev_kind == 3) e_done = 1;
            else e_short = 1;
        end
    endtask

    task automatic compare();
        chk("n_out", N_out, e_out[0]);
        chk("d_out", D_out, e_out[1]);
        chk("q_out", Q_out, e_out[2]);
        chk("done", done, e_done);
        chk("short", short, e_short);
        chk("busy", busy, m_active);
        chk("rem_nk", rem_nk, m_rem);
        chk("n_cnt", N_cnt, m_cnt[0]);
        chk("d_cnt", D_cnt, m_cnt[1]);
        chk("q_cnt", Q_cnt, m_cnt[2]);
        if (N_out === 1'b1) begin obs_kind.push_back(0); obs_cyc.push_back(cyc); end
        if (D_out === 1'b1) begin obs_kind.push_back(1); obs_cyc.push_back(cyc); end
        if (Q_out === 1'b1) begin obs_kind.push_back(2); obs_cyc.push_back(cyc); end
        if (done === 1'b1) begin obs_kind.push_back(3); obs_cyc.push_back(cyc); end
        if (short === 1'b1) begin obs_kind.push_back(4); obs_cyc.push_back(cyc); end
        if (busy === 1'b1) busy_seen++;
    endtask

    // One clock: model consumes this cycle's inputs, then outputs are checked
    // 1ns after the edge and all strobes are released.
    task automatic step();
        @(posedge clk);
        model_edge();
        model_cycle();
        #1;
        compare();
        reset = 0; start = 0; refill = 0; N_in = 0; D_in = 0; Q_in = 0;
    endtask

    task automatic clear_log();
        obs_kind.delete();
        obs_cyc.delete();
        busy_seen = 0;
    endtask

    task automatic chk_ev(input int idx, input int kind, input int at);
        if (idx < obs_kind.size()) begin
            chk($sformatf("ev%0d_kind", idx), obs_kind[idx], kind);
            chk($sformatf("ev%0d_cyc", idx), obs_cyc[idx], at);
        end else begin
            chk($sformatf("ev%0d_missing", idx), obs_kind.size(), idx + 1);
        end
    endtask

    initial begin
        int s;
        // Reset state
        reset = 1; step();
        reset = 1; step();
        chk("rst_busy", busy, 0);
        chk("rst_rem", rem_nk, 0);
        chk("rst_qcnt", Q_cnt, 0);
        chk("rst_state", state_dbg, S_IDLE);

        // Refill, 8 nickels -> Q, D, N three cycles apart, then done
        refill = 1; step();
        clear_log();
        s = cyc; start = 1; change_nk = 5'd8; step();
        repeat (12) step();
        chk("c8_nev", obs_kind.size(), 4);
        chk_ev(0, 2, s + 2);
        chk_ev(1, 1, s + 5);
        chk_ev(2, 0, s + 8);
        chk_ev(3, 3, s + 11);
        chk("c8_cnt", {N_cnt, D_cnt, Q_cnt}, {4'd14, 4'd14, 4'd14});
        chk("c8_rem", rem_nk, 0);

        // Q=0, D=2, N=1 via deposits, 5 nickels -> D, D, N, done
        reset = 1; step();
        D_in = 1; step();
        D_in = 1; step();
        N_in = 1; step();
        clear_log();
        s = cyc; start = 1; change_nk = 5'd5; step();
        repeat (12) step();
        chk("c5_nev", obs_kind.size(), 4);
        chk_ev(0, 1, s + 2);
        chk_ev(1, 1, s + 5);
        chk_ev(2, 0, s + 8);
        chk_ev(3, 3, s + 11);
        chk("c5_cnt", {N_cnt, D_cnt, Q_cnt}, 12'd0);

        // Empty tubes, 3 nickels -> short at k+2, rem stays 3
        clear_log();
        s = cyc; start = 1; change_nk = 5'd3; step();
        repeat (4) step();
        chk("c3_nev", obs_kind.size(), 1);
        chk_ev(0, 4, s + 2);
        chk("c3_rem", rem_nk, 3);

        // Zero change -> done at k+2, busy for two cycles
        clear_log();
        s = cyc; start = 1; change_nk = 5'd0; step();
        repeat (4) step();
        chk("c0_nev", obs_kind.size(), 1);
        chk_ev(0, 3, s + 2);
        chk("c0_busy", busy_seen, 2);

        // Reset in the gap after the first Q
        refill = 1; step();
        clear_log();
        s = cyc; start = 1; change_nk = 5'd10; step();
        step();
        step();
        chk_ev(0, 2, s + 2);
        reset = 1; start = 1; step();
        chk("rg_outs", {N_out, D_out, Q_out, busy, done, short}, 6'd0);
        chk("rg_cnt", {N_cnt, D_cnt, Q_cnt}, 12'd0);
        chk("rg_state", state_dbg, S_IDLE);

        // Saturation, deposit coincident with eject, refill while busy
        refill = 1; step();
        Q_in = 1; step();
        chk("sat_q", Q_cnt, 15);
        s = cyc; start = 1; change_nk = 5'd10; step();
        step();
        chk("co_qout", Q_out, 1);
        Q_in = 1; step();
        chk("co_qcnt", Q_cnt, 15);
        step(); step(); step();
        refill = 1; step();
        repeat (4) step();
        chk("rb_qcnt", Q_cnt, 14);
        chk("rb_dcnt", D_cnt, 15);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            change_nk = 5'($urandom_range(0, 31));
            N_in      = ($urandom_range(0, 3) == 0);
            D_in      = ($urandom_range(0, 3) == 0);
            Q_in      = ($urandom_range(0, 4) == 0);
            refill    = ($urandom_range(0, 60) == 0);
            reset     = ($urandom_range(0, 400) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
